mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one slow-memory port between the instruction-cache and data-cache refill/write-back interfaces.
- Sits between the two cache instances and the external memory, in place of the two dedicated memory ports.
- Arbitration is fixed priority in favour of the D-cache, plus aging so the I-cache cannot be starved.
- Grants are held until the memory handshake completes; a bus-turnaround cycle follows every transaction.

Parameters:
- MAX_LOSS, 2: consecutive lost arbitrations after which the I-cache wins the next conflict.
- LOSS_W, 2: width of the loss counter. Must satisfy 2^LOSS_W > MAX_LOSS.
- CNT_W, 16: width of the conflict statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- memI_read  in  1  I-cache read request
- memI_write  in  1  I-cache write request
- memI_addr  in  28  I-cache block address [31:4]
- memI_wdata  in  128  I-cache write block
- memI_rdata  out  128  read block returned to I-cache
- memI_ready  out  1  transaction done, I-cache
- memD_read  in  1  D-cache read request
- memD_write  in  1  D-cache write request
- memD_addr  in  28  D-cache block address [31:4]
- memD_wdata  in  128  D-cache write block
- memD_rdata  out  128  read block returned to D-cache
- memD_ready  out  1  transaction done, D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  28  memory block address
- mem_wdata  out  128  memory write data
- mem_rdata  in  128  memory read data
- mem_ready  in  1  memory transaction done
- grant_I  out  1  state is BUSY_I
- grant_D  out  1  state is BUSY_D
- conflict_cnt  out  CNT_W  saturating count of conflicts

Behaviour:
- Reset and clock:
  - Reset is rst_n, asynchronous, active-low. Clock is clk; all state updates on its rising edge.
  - On reset: state=IDLE, loss_cnt=0, conflict_cnt=0. Every output is 0, including both rdata buses.
- Requests:
  - reqI = memI_read | memI_write.
  - reqD = memD_read | memD_write.
- States: IDLE, BUSY_I, BUSY_D, TURN.
- IDLE:
  - Downstream mem_read, mem_write, mem_addr and mem_wdata are all 0.
  - Both ready outputs are 0.
  - Only reqI: go to BUSY_I.
  - Only reqD: go to BUSY_D.
  - Both requesting:
    - If loss_cnt >= MAX_LOSS: go to BUSY_I.
    - Otherwise: go to BUSY_D and increment loss_cnt.
    - In either case conflict_cnt increments, saturating at all-ones.
  - No request: stay in IDLE.
- BUSY_x (x = I or D):
  - mem_read, mem_write, mem_addr and mem_wdata are driven combinationally from requester x, unmodified. Both strobes are passed through as-is.
  - memx_ready = mem_ready. The other requester's ready stays 0.
  - memx_rdata = mem_rdata. The other requester's rdata holds 0.
  - When mem_ready=1 is sampled: go to TURN.
  - Entering BUSY_I clears loss_cnt.
- TURN:
  - Lasts exactly one cycle. All downstream strobes and both ready outputs are 0.
  - Next state is always IDLE. This gives the finished cache one cycle to drop its request.
- Latency:
  - A request sampled in IDLE at edge t appears downstream in cycle t+1.
  - Minimum back-to-back spacing is mem latency + 2 cycles.
- A non-granted request may be held indefinitely. It is never dropped and never reordered.
- Protocol violation (granted requester drops both strobes before mem_ready):
  - Go to TURN on the next edge and then to IDLE.
  - The downstream strobes follow the requester, so they drop immediately.
  - loss_cnt and conflict_cnt are unaffected.
- mem_ready=1 while in IDLE or TURN is ignored.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. Counters are cleared.
- loss_cnt is cleared only by a grant to I. A grant to D when I is not requesting leaves it unchanged.

Test Plan:
- Single I read:
  - Stimulus: memI_read=1, addr=0x0000010, memory ready after 4 cycles, rdata=0xA5..A5.
  - Response: mem_read=1 and mem_addr=0x0000010 one cycle later. memI_ready pulses with memI_rdata=0xA5..A5. memD_ready stays 0. TURN follows, then IDLE.
- Simultaneous first conflict:
  - Stimulus: memI_read and memD_write assert in the same cycle.
  - Response: D is granted first, with mem_write=1 and mem_wdata=memD_wdata. loss_cnt=1, conflict_cnt=1. I is served after D's TURN cycle.
- Aging with MAX_LOSS=2:
  - Stimulus: both requesters conflict three times in a row, each time re-requesting after being served.
  - Response: the third conflict grants I. loss_cnt returns to 0 and conflict_cnt=3.
- Held requests:
  - Stimulus: D holds its request through a 10-cycle I transaction.
  - Response: mem_addr never shows memD_addr during BUSY_I. D is granted in the IDLE following TURN.
- Reset mid-BUSY_D:
  - Stimulus: assert rst_n=0 two cycles into a BUSY_D transaction.
  - Response: mem_write, grant_D and conflict_cnt are all 0 immediately, without waiting for a clock edge.
- Conflict counter saturation:
  - Stimulus: run with CNT_W=2 and apply 5 conflicts.
  - Response: conflict_cnt stays at 3.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Block-level memory port bundle: request strobes, address and write data
// flow from master to slave; read data and completion flow back.
`timescale 1ns/1ps

interface mem_port_arbiter_if;
    logic         read;
    logic         write;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         ready;

    // Requester side (a cache, or the arbiter facing external memory)
    modport master (
        output read, write, addr, wdata,
        input  rdata, ready
    );

    // Responder side (the arbiter facing a cache, or the memory)
    modport slave (
        input  read, write, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one slow memory port between the I-cache and D-cache.
// The D-cache has fixed priority; an aging counter lets the I-cache win a
// conflict after MAX_LOSS consecutive losses. A grant lasts until the memory
// reports completion (or the owner drops its request), and is always
// followed by a single bus-turnaround cycle.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int MAX_LOSS = 2,
    parameter int LOSS_W   = 2,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  memI,
    mem_port_arbiter_if.slave  memD,
    mem_port_arbiter_if.master mem,
    output logic               grant_I,
    output logic               grant_D,
    output logic [CNT_W-1:0]   conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        TURN   = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [LOSS_W-1:0]  loss_cnt_reg;
    logic [LOSS_W-1:0]  loss_cnt_next;
    logic [CNT_W-1:0]   conflict_cnt_reg;
    logic [CNT_W-1:0]   conflict_cnt_next;

    logic req_icache;
    logic req_dcache;

    assign req_icache   = memI.read | memI.write;
    assign req_dcache   = memD.read | memD.write;
    assign conflict_cnt = conflict_cnt_reg;

    // State and counter registers; reset acts immediately, not at the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            loss_cnt_reg     <= '0;
            conflict_cnt_reg <= '0;
        end else begin
            state_reg        <= state_next;
            loss_cnt_reg     <= loss_cnt_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    // Next-state selection and the combinational bus steering for the owner
    always_comb begin
        state_next        = state_reg;
        loss_cnt_next     = loss_cnt_reg;
        conflict_cnt_next = conflict_cnt_reg;

        mem.read   = 1'b0;
        mem.write  = 1'b0;
        mem.addr   = '0;
        mem.wdata  = '0;
        memI.rdata = '0;
        memI.ready = 1'b0;
        memD.rdata = '0;
        memD.ready = 1'b0;
        grant_I    = 1'b0;
        grant_D    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_icache && req_dcache) begin
                    if (conflict_cnt_reg != '1) begin
                        conflict_cnt_next = conflict_cnt_reg + 1'b1;
                    end
                    // Aging: after enough consecutive losses the I-cache wins
                    if (loss_cnt_reg >= LOSS_W'(MAX_LOSS)) begin
                        state_next    = BUSY_I;
                        loss_cnt_next = '0;
                    end else begin
                        state_next    = BUSY_D;
                        loss_cnt_next = loss_cnt_reg + 1'b1;
                    end
                end else if (req_icache) begin
                    state_next    = BUSY_I;
                    loss_cnt_next = '0;
                end else if (req_dcache) begin
                    // An uncontested D grant is not a loss for the I-cache
                    state_next = BUSY_D;
                end
            end

            BUSY_I: begin
                grant_I    = 1'b1;
                mem.read   = memI.read;
                mem.write  = memI.write;
                mem.addr   = memI.addr;
                mem.wdata  = memI.wdata;
                memI.rdata = mem.rdata;
                memI.ready = mem.ready;
                // Dropping the request early abandons the transaction
                if (mem.ready || !req_icache) begin
                    state_next = TURN;
                end
            end

            BUSY_D: begin
                grant_D    = 1'b1;
                mem.read   = memD.read;
                mem.write  = memD.write;
                mem.addr   = memD.addr;
                mem.wdata  = memD.wdata;
                memD.rdata = mem.rdata;
                memD.ready = mem.ready;
                if (mem.ready || !req_dcache) begin
                    state_next = TURN;
                end
            end

            TURN: begin
                // Gives the finished cache a cycle to withdraw its request
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cache agents replay queued block
// transactions, a memory responder answers after mem_lat cycles, and a
// phase-level model predicts every output on every cycle. A second instance
// with a 2-bit conflict counter shares the same stimulus.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int MAX_LOSS = 2;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        int           hold;   // >0: abandon after this many cycles
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if memI ();
    mem_port_arbiter_if memD ();
    mem_port_arbiter_if mem  ();
    mem_port_arbiter_if memI2 ();
    mem_port_arbiter_if memD2 ();
    mem_port_arbiter_if mem2  ();

    logic        gI, gD, gI2, gD2;
    logic [15:0] ccnt;
    logic [1:0]  ccnt2;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .memI(memI), .memD(memD), .mem(mem),
        .grant_I(gI), .grant_D(gD), .conflict_cnt(ccnt)
    );

    mem_port_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .memI(memI2), .memD(memD2), .mem(mem2),
        .grant_I(gI2), .grant_D(gD2), .conflict_cnt(ccnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int glog     = 0;
    int mem_lat  = 4;
    bit chk_en   = 1'b0;
    txn_t qI[$];
    txn_t qD[$];

    logic         resp_ready  = 1'b0;
    logic         force_ready = 1'b0;
    logic [127:0] rdata_val   = {16{8'hA5}};

    assign mem.ready  = resp_ready | force_ready;
    assign mem.rdata  = rdata_val;
    assign mem2.ready = mem.ready;
    assign mem2.rdata = mem.rdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [27:0] a, input logic [127:0] d, input int hold);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = d; t.hold = hold;
        return t;
    endfunction

    // Cache agents: present one queued transaction at a time, hold it until
    // ready (or abandon it), then withdraw for one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : agent
        logic         rd    = 1'b0;
        logic         wr    = 1'b0;
        logic [27:0]  addr  = '0;
        logic [127:0] wdata = '0;
        bit           busy  = 1'b0;
        initial begin : run
            txn_t t;
            int   n;
            bit   have, done, rdy;
            forever begin
                @(posedge clk); #1;
                have = 1'b0;
                if (rst_n) begin
                    if (gi == 0 && qI.size() != 0) begin t = qI.pop_front(); have = 1'b1; end
                    if (gi == 1 && qD.size() != 0) begin t = qD.pop_front(); have = 1'b1; end
                end
                if (have) begin
                    busy = 1'b1; rd = !t.wr; wr = t.wr; addr = t.addr; wdata = t.wdata;
                    n = 0; done = 1'b0;
                    while (!done) begin
                        @(negedge clk); #1;
                        n++;
                        rdy = (gi == 0) ? memI.ready : memD.ready;
                        if (!rst_n) done = 1'b1;
                        else if (rdy) done = 1'b1;
                        else if (t.hold > 0 && n >= t.hold) done = 1'b1;
                        else if (n > 400) begin
                            n_checks++; n_fail++;
                            $display("FAIL agent%0d_timeout: no ready after %0d cycles", gi, n);
                            done = 1'b1;
                        end
                    end
                    if (rst_n) begin @(posedge clk); #1; end
                    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; busy = 1'b0;
                end
            end
        end
    end

    assign memI.read  = agent[0].rd;
    assign memI.write = agent[0].wr;
    assign memI.addr  = agent[0].addr;
    assign memI.wdata = agent[0].wdata;
    assign memD.read  = agent[1].rd;
    assign memD.write = agent[1].wr;
    assign memD.addr  = agent[1].addr;
    assign memD.wdata = agent[1].wdata;
    assign memI2.read  = memI.read;
    assign memI2.write = memI.write;
    assign memI2.addr  = memI.addr;
    assign memI2.wdata = memI.wdata;
    assign memD2.read  = memD.read;
    assign memD2.write = memD.write;
    assign memD2.addr  = memD.addr;
    assign memD2.wdata = memD.wdata;

    // Memory: raises ready for one cycle after mem_lat cycles of a steady strobe
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #2;
            if (!rst_n || resp_ready) begin
                resp_ready = 1'b0; cnt = 0;
            end else if (mem.read || mem.write) begin
                cnt++;
                if (cnt >= mem_lat) resp_ready = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Model: phase 0 idle, 1 serving I, 2 serving D, 3 turnaround.
    int m_phase = 0;
    int m_loss  = 0;
    int m_conf  = 0;
    bit m_ri, m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_loss = 0; m_conf = 0;
        end else begin
            m_ri = memI.read | memI.write;
            m_rd = memD.read | memD.write;
            if (m_phase == 0) begin
                if (m_ri && m_rd) begin
                    m_conf++;
                    if (m_loss >= MAX_LOSS) begin m_phase = 1; m_loss = 0; end
                    else begin m_phase = 2; m_loss++; end
                end else if (m_ri) begin
                    m_phase = 1; m_loss = 0;
                end else if (m_rd) begin
                    m_phase = 2;
                end
            end else if (m_phase == 1) begin
                if (mem.ready || !m_ri) m_phase = 3;
            end else if (m_phase == 2) begin
                if (mem.ready || !m_rd) m_phase = 3;
            end else begin
                m_phase = 0;
            end
        end
    end

    logic         e_rd, e_wr, e_yI, e_yD, e_gI, e_gD, prev_gI, prev_gD;
    logic [27:0]  e_addr;
    logic [127:0] e_wd, e_rI, e_rD;
    logic [15:0]  e_cc16;
    logic [1:0]   e_cc2;

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            e_gI = (m_phase == 1); e_gD = (m_phase == 2);
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
            e_yI = 1'b0; e_yD = 1'b0; e_rI = '0; e_rD = '0;
            if (m_phase == 1) begin
                e_rd = memI.read; e_wr = memI.write; e_addr = memI.addr; e_wd = memI.wdata;
                e_yI = mem.ready; e_rI = mem.rdata;
            end else if (m_phase == 2) begin
                e_rd = memD.read; e_wr = memD.write; e_addr = memD.addr; e_wd = memD.wdata;
                e_yD = mem.ready; e_rD = mem.rdata;
            end
            e_cc16 = (m_conf > 65535) ? 16'hFFFF : 16'(m_conf);
            e_cc2  = (m_conf > 3) ? 2'd3 : 2'(m_conf);
            chk("grant_I",      128'(gI),         128'(e_gI));
            chk("grant_D",      128'(gD),         128'(e_gD));
            chk("mem_read",     128'(mem.read),   128'(e_rd));
            chk("mem_write",    128'(mem.write),  128'(e_wr));
            chk("mem_addr",     128'(mem.addr),   128'(e_addr));
            chk("mem_wdata",    mem.wdata,        e_wd);
            chk("memI_ready",   128'(memI.ready), 128'(e_yI));
            chk("memI_rdata",   memI.rdata,       e_rI);
            chk("memD_ready",   128'(memD.ready), 128'(e_yD));
            chk("memD_rdata",   memD.rdata,       e_rD);
            chk("conflict_cnt", 128'(ccnt),       128'(e_cc16));
            chk("sat_grant_I",  128'(gI2),         128'(e_gI));
            chk("sat_grant_D",  128'(gD2),         128'(e_gD));
            chk("sat_mem_read", 128'(mem2.read),   128'(e_rd));
            chk("sat_mem_write",128'(mem2.write),  128'(e_wr));
            chk("sat_mem_addr", 128'(mem2.addr),   128'(e_addr));
            chk("sat_mem_wdata",mem2.wdata,        e_wd);
            chk("sat_memI_ready",128'(memI2.ready),128'(e_yI));
            chk("sat_memI_rdata",memI2.rdata,      e_rI);
            chk("sat_memD_ready",128'(memD2.ready),128'(e_yD));
            chk("sat_memD_rdata",memD2.rdata,      e_rD);
            chk("sat_conflict_cnt",128'(ccnt2),    128'(e_cc2));
            if (gI && !prev_gI) glog = glog * 10 + 1;
            if (gD && !prev_gD) glog = glog * 10 + 2;
            prev_gI = gI; prev_gD = gD;
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        qI.delete(); qD.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        glog = 0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (qI.size() == 0 && qD.size() == 0 && !agent[0].busy && !agent[1].busy && m_phase == 0) return;
        end
        n_checks++; n_fail++;
        $display("FAIL %s_idle_timeout: arbiter still busy after 300 cycles, required idle", name);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        prev_gI = 1'b0; prev_gD = 1'b0;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        // Reset state, with nonzero data on the memory bus
        @(negedge clk);
        chk("rst_grant_I", 128'(gI), 128'(0));
        chk("rst_conflict_cnt", 128'(ccnt), 128'(0));
        chk("rst_memI_rdata", memI.rdata, 128'(0));
        chk("rst_mem_read", 128'(mem.read), 128'(0));
        do_reset();

        // Single I read, memory answers in the 4th busy cycle
        mem_lat = 4;
        qI.push_back(mk(1'b0, 28'h0000010, '0, 0));
        @(negedge clk);
        chk("t1_early_grant_I", 128'(gI), 128'(0));
        @(negedge clk);
        chk("t1_mem_read", 128'(mem.read), 128'(1));
        chk("t1_mem_addr", 128'(mem.addr), 128'(28'h0000010));
        repeat (3) @(negedge clk);
        chk("t1_memI_ready", 128'(memI.ready), 128'(1));
        chk("t1_memI_rdata", memI.rdata, {16{8'hA5}});
        chk("t1_memD_ready", 128'(memD.ready), 128'(0));
        @(negedge clk);
        chk("t1_turn_grant_I", 128'(gI), 128'(0));
        chk("t1_turn_memI_ready", 128'(memI.ready), 128'(0));
        wait_idle("t1");

        // First conflict: D wins, I follows after turnaround
        do_reset();
        qI.push_back(mk(1'b0, 28'h0000100, '0, 0));
        qD.push_back(mk(1'b1, 28'h0000200, {4{32'hD1D1_0001}}, 0));
        repeat (2) @(negedge clk);
        chk("t2_grant_D", 128'(gD), 128'(1));
        chk("t2_mem_write", 128'(mem.write), 128'(1));
        chk("t2_mem_wdata", mem.wdata, {4{32'hD1D1_0001}});
        chk("t2_conflict_cnt", 128'(ccnt), 128'(1));
        wait_idle("t2");
        chk("t2_order", 128'(glog), 128'(21));

        // Aging: three back-to-back conflicts, the third goes to I
        do_reset();
        mem_lat = 2;
        for (int k = 0; k < 3; k++) qD.push_back(mk(1'b1, 28'h0000300 + 28'(k), {4{32'(k)}}, 0));
        qI.push_back(mk(1'b0, 28'h0000400, '0, 0));
        wait_idle("t3");
        chk("t3_order", 128'(glog), 128'(2212));
        chk("t3_conflict_cnt", 128'(ccnt), 128'(3));
        // Aging history was cleared by the I grant: next conflict goes to D
        qI.push_back(mk(1'b0, 28'h0000410, '0, 0));
        qD.push_back(mk(1'b0, 28'h0000310, '0, 0));
        wait_idle("t3b");
        chk("t3_order_after", 128'(glog), 128'(221221));
        chk("t3_conflict_cnt_after", 128'(ccnt), 128'(4));

        // D held through a 10-cycle I transaction
        do_reset();
        mem_lat = 10;
        qI.push_back(mk(1'b0, 28'h0000500, '0, 0));
        @(negedge clk);
        qD.push_back(mk(1'b0, 28'h0000600, '0, 0));
        repeat (3) @(negedge clk);
        chk("t4_mem_addr", 128'(mem.addr), 128'(28'h0000500));
        chk("t4_grant_D", 128'(gD), 128'(0));
        wait_idle("t4");
        chk("t4_order", 128'(glog), 128'(12));
        chk("t4_conflict_cnt", 128'(ccnt), 128'(0));

        // mem_ready in IDLE is ignored; then I abandons its request
        do_reset();
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_idle_grant_I", 128'(gI), 128'(0));
        chk("t5_idle_memD_ready", 128'(memD.ready), 128'(0));
        force_ready = 1'b0;
        qI.push_back(mk(1'b0, 28'h0000700, '0, 3));
        repeat (4) @(negedge clk);
        chk("t5_drop_grant_I", 128'(gI), 128'(1));
        chk("t5_drop_mem_read", 128'(mem.read), 128'(0));
        @(negedge clk);
        chk("t5_turn_grant_I", 128'(gI), 128'(0));
        mem_lat = 3;
        qD.push_back(mk(1'b0, 28'h0000710, '0, 0));
        wait_idle("t5");
        chk("t5_order", 128'(glog), 128'(12));

        // Reset in the middle of a D write
        do_reset();
        mem_lat = 10;
        qI.push_back(mk(1'b0, 28'h0000800, '0, 0));
        qD.push_back(mk(1'b1, 28'h0000900, {4{32'hCAFE_0009}}, 0));
        repeat (2) @(negedge clk);
        chk("t6_grant_D", 128'(gD), 128'(1));
        chk("t6_conflict_cnt", 128'(ccnt), 128'(1));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_write", 128'(mem.write), 128'(0));
        chk("t6_rst_grant_D", 128'(gD), 128'(0));
        chk("t6_rst_conflict_cnt", 128'(ccnt), 128'(0));
        chk("t6_rst_sat_conflict_cnt", 128'(ccnt2), 128'(0));
        do_reset();

        // Five conflicts: 16-bit counter reads 5, 2-bit counter sticks at 3
        mem_lat = 1;
        for (int k = 0; k < 4; k++) qD.push_back(mk(1'b0, 28'h0000A00 + 28'(k), '0, 0));
        for (int k = 0; k < 2; k++) qI.push_back(mk(1'b0, 28'h0000B00 + 28'(k), '0, 0));
        wait_idle("t7");
        chk("t7_order", 128'(glog), 128'(221221));
        chk("t7_conflict_cnt", 128'(ccnt), 128'(5));
        chk("t7_sat_conflict_cnt", 128'(ccnt2), 128'(3));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
